// File: rtl/mining_pkg.sv
// Shared constants and types for the mining-path memory readout.
package mining_pkg;

    localparam int unsigned DATA_WIDTH      = 8;
    localparam int unsigned DATA_DEPTH      = 512;
    localparam int unsigned ADDR_WIDTH      = 9;
    localparam int unsigned WORD_WIDTH      = 32;
    localparam int unsigned WORDS_PER_CHUNK = 16;

    // Readout sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } packer_state_t;

endpackage

// File: rtl/byte_packer.sv
// Big-endian byte-to-word shift register; first captured byte ends up in the MSBs.
module byte_packer #(
    parameter int unsigned DATA_WIDTH = mining_pkg::DATA_WIDTH,
    parameter int unsigned WORD_WIDTH = mining_pkg::WORD_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  cap_en,
    input  logic [DATA_WIDTH-1:0] byte_in,
    output logic [WORD_WIDTH-1:0] word,
    output logic                  word_full
);

    localparam int unsigned BYTES = WORD_WIDTH / DATA_WIDTH;
    localparam int unsigned CNT_W = $clog2(BYTES) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BYTES - 1);

    logic [CNT_W-1:0] cnt_q;

    // Shift in one byte per capture; flag the word once the last byte lands
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word      <= '0;
            cnt_q     <= '0;
            word_full <= 1'b0;
        end else if (clear) begin
            word      <= '0;
            cnt_q     <= '0;
            word_full <= 1'b0;
        end else if (cap_en) begin
            word      <= {word[WORD_WIDTH-DATA_WIDTH-1:0], byte_in};
            cnt_q     <= cnt_q + CNT_W'(1);
            word_full <= (cnt_q == LAST_CNT);
        end
    end

endmodule

// File: rtl/mem_word_packer.sv
// Walks the block-data memory 0..DEPTH-1 and streams big-endian packed words
// to the message scheduler over valid/ready, tagging chunk and block ends.
module mem_word_packer #(
    parameter int unsigned DATA_WIDTH      = mining_pkg::DATA_WIDTH,
    parameter int unsigned DATA_DEPTH      = mining_pkg::DATA_DEPTH,
    parameter int unsigned ADDR_WIDTH      = mining_pkg::ADDR_WIDTH,
    parameter int unsigned WORD_WIDTH      = mining_pkg::WORD_WIDTH,
    parameter int unsigned WORDS_PER_CHUNK = mining_pkg::WORDS_PER_CHUNK
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  fine_scrittura,
    input  logic [DATA_WIDTH-1:0] out_mem,
    output logic [ADDR_WIDTH-1:0] indirizzo_read,
    output logic [WORD_WIDTH-1:0] word_out,
    output logic                  word_valid,
    input  logic                  word_ready,
    output logic                  chunk_last,
    output logic                  block_last,
    output logic                  busy,
    output logic                  done
);

    import mining_pkg::*;

    localparam int unsigned BYTES     = WORD_WIDTH / DATA_WIDTH;
    localparam int unsigned NUM_WORDS = DATA_DEPTH / BYTES;
    localparam int unsigned WIDX_W    = $clog2(NUM_WORDS);
    localparam int unsigned CHUNK_W   = $clog2(WORDS_PER_CHUNK);
    localparam int unsigned ICNT_W    = $clog2(BYTES) + 1;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR     = ADDR_WIDTH'(DATA_DEPTH - 1);
    localparam logic [WIDX_W-1:0]     LAST_WORD     = WIDX_W'(NUM_WORDS - 1);
    localparam logic [CHUNK_W-1:0]    LAST_IN_CHUNK = CHUNK_W'(WORDS_PER_CHUNK - 1);
    localparam logic [ICNT_W-1:0]     ISSUE_MAX     = ICNT_W'(BYTES);

    packer_state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] addr_d;
    logic [ICNT_W-1:0]     icnt_q, icnt_d;
    logic [WIDX_W-1:0]     widx_q, widx_d;
    logic                  cap_pipe_q;
    logic [WORD_WIDTH-1:0] word_out_d;
    logic                  word_valid_d;
    logic                  chunk_last_d;
    logic                  block_last_d;
    logic                  busy_d;
    logic                  done_d;
    logic                  issue_c;
    logic                  pk_clear_c;
    logic [WORD_WIDTH-1:0] pk_word;
    logic                  pk_full;

    // Byte assembly; capture strobe trails each issued address by the read latency
    byte_packer #(
        .DATA_WIDTH (DATA_WIDTH),
        .WORD_WIDTH (WORD_WIDTH)
    ) u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (pk_clear_c),
        .cap_en    (cap_pipe_q),
        .byte_in   (out_mem),
        .word      (pk_word),
        .word_full (pk_full)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, address issue and registered-output next values
    always_comb begin
        state_d      = state_q;
        addr_d       = indirizzo_read;
        icnt_d       = icnt_q;
        widx_d       = widx_q;
        word_out_d   = word_out;
        word_valid_d = word_valid;
        chunk_last_d = chunk_last;
        block_last_d = block_last;
        busy_d       = busy;
        done_d       = 1'b0;
        issue_c      = 1'b0;
        pk_clear_c   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && fine_scrittura) begin
                    state_d    = FETCH;
                    addr_d     = '0;
                    icnt_d     = '0;
                    widx_d     = '0;
                    busy_d     = 1'b1;
                    pk_clear_c = 1'b1;
                end
            end
            FETCH: begin
                if (icnt_q != ISSUE_MAX) begin
                    issue_c = 1'b1;
                end
                if (pk_full) begin
                    state_d      = HOLD;
                    word_out_d   = pk_word;
                    word_valid_d = 1'b1;
                    chunk_last_d = (widx_q[CHUNK_W-1:0] == LAST_IN_CHUNK);
                    block_last_d = (widx_q == LAST_WORD);
                    pk_clear_c   = 1'b1;
                    icnt_d       = '0;
                end
            end
            HOLD: begin
                if (word_ready) begin
                    word_valid_d = 1'b0;
                    chunk_last_d = 1'b0;
                    block_last_d = 1'b0;
                    if (widx_q == LAST_WORD) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        // The handshake edge also issues the already-presented next address
                        state_d = FETCH;
                        widx_d  = widx_q + WIDX_W'(1);
                        issue_c = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Address saturates at the last location so it never wraps
        if (issue_c) begin
            icnt_d = icnt_q + ICNT_W'(1);
            if (indirizzo_read != LAST_ADDR) begin
                addr_d = indirizzo_read + ADDR_WIDTH'(1);
            end
        end
    end

    // Counters, capture pipeline and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            indirizzo_read <= '0;
            icnt_q         <= '0;
            widx_q         <= '0;
            cap_pipe_q     <= 1'b0;
            word_out       <= '0;
            word_valid     <= 1'b0;
            chunk_last     <= 1'b0;
            block_last     <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            indirizzo_read <= addr_d;
            icnt_q         <= icnt_d;
            widx_q         <= widx_d;
            cap_pipe_q     <= issue_c;
            word_out       <= word_out_d;
            word_valid     <= word_valid_d;
            chunk_last     <= chunk_last_d;
            block_last     <= block_last_d;
            busy           <= busy_d;
            done           <= done_d;
        end
    end

endmodule
